// File: rtl/operand_fetch.sv
// Operand fetch: register file, R-type decode to ALUop, and a registered operand slot.
// Latency 1 cycle from capture to out_valid; no skid, so instr_ready drops while a result is held.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [3:0]      ALUop,
  output logic [AW-1:0]   rd,
  output logic            illegal
);

  localparam int NREGS = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREGS];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            illegal_q, illegal_d;

  logic            capture;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [AW-1:0]   rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  logic [3:0]      dec_op;
  logic            dec_ill;

  assign instr_ready = !out_valid_q || out_ready;
  assign capture     = instr_valid && instr_ready;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rs1_idx = instr[15 +: AW];
  assign rs2_idx = instr[20 +: AW];

  always_comb begin
    dec_op  = 4'b1111;
    dec_ill = 1'b1;
    if (opcode == 7'b0110011) begin
      dec_ill = 1'b0;
      unique case ({f7, f3})
        {7'b0000000, 3'b000}: dec_op = 4'b1001;
        {7'b0100000, 3'b000}: dec_op = 4'b0001;
        {7'b0000000, 3'b100}: dec_op = 4'b0010;
        {7'b0000000, 3'b110}: dec_op = 4'b0011;
        {7'b0000000, 3'b111}: dec_op = 4'b0100;
        {7'b0000000, 3'b001}: dec_op = 4'b0101;
        {7'b0000000, 3'b101}: dec_op = 4'b1101;
        default: begin
          dec_op  = 4'b1111;
          dec_ill = 1'b1;
        end
      endcase
    end
  end

  // Write-first read: a same-cycle write-back to a source register wins over the array.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1_idx != '0)
      rs1_rd = (wb_en && (wb_addr == rs1_idx)) ? wb_data : regs_q[rs1_idx];
    if (rs2_idx != '0)
      rs2_rd = (wb_en && (wb_addr == rs2_idx)) ? wb_data : regs_q[rs2_idx];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    illegal_d   = illegal_q;
    if (capture) begin
      out_valid_d = 1'b1;
      rs1_d       = rs1_rd;
      rs2_d       = rs2_rd;
      alu_op_d    = dec_op;
      rd_d        = instr[11:7];
      illegal_d   = dec_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_op_q    <= 4'b1111;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign ALUop     = alu_op_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Operand fetch bench: directed scenarios plus random traffic against an architectural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  ALUop;
  logic [4:0]  rd;
  logic        illegal;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .ALUop(ALUop), .rd(rd), .illegal(illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: register contents and the operation currently presented.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_rs1, m_rs2;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] s2,
                                     input logic [4:0] s1, input logic [2:0] f3,
                                     input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  // Returns {illegal, ALUop} for an instruction word.
  function automatic logic [4:0] ref_decode(input logic [31:0] ins);
    logic [9:0] key;
    key = {ins[31:25], ins[14:12]};
    if (ins[6:0] != 7'b0110011) return 5'b11111;
    case (key)
      10'b0000000_000: return 5'b0_1001;
      10'b0100000_000: return 5'b0_0001;
      10'b0000000_100: return 5'b0_0010;
      10'b0000000_110: return 5'b0_0011;
      10'b0000000_111: return 5'b0_0100;
      10'b0000000_001: return 5'b0_0101;
      10'b0000000_101: return 5'b0_1101;
      default:         return 5'b11111;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return m_regs[idx];
  endfunction

  task automatic check_outputs(input string pfx);
    check_eq({pfx, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check_eq({pfx, ".rs1"},       rs1, m_rs1);
    check_eq({pfx, ".rs2"},       rs2, m_rs2);
    check_eq({pfx, ".ALUop"},     {28'd0, ALUop}, {28'd0, m_op});
    check_eq({pfx, ".rd"},        {27'd0, rd}, {27'd0, m_rd});
    check_eq({pfx, ".illegal"},   {31'd0, illegal}, {31'd0, m_ill});
  endtask

  // One clock: drive inputs, check instr_ready, advance the model, check registered outputs.
  task automatic cycle(input string pfx, input logic r, input logic iv, input logic [31:0] ins,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy);
    logic [4:0] dec;
    logic       cap;
    rst = r; instr_valid = iv; instr = ins;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    if (!r) check_eq({pfx, ".instr_ready"}, {31'd0, instr_ready}, {31'd0, (!m_valid || ordy)});
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_rs1 = 32'd0; m_rs2 = 32'd0;
      m_op = 4'b1111; m_rd = 5'd0; m_ill = 1'b0;
    end else begin
      cap = iv && (!m_valid || ordy);
      if (cap) begin
        dec     = ref_decode(ins);
        m_rs1   = ref_read(ins[19:15], we, wa, wd);
        m_rs2   = ref_read(ins[24:20], we, wa, wd);
        m_op    = dec[3:0];
        m_ill   = dec[4];
        m_rd    = ins[11:7];
        m_valid = 1'b1;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (we && wa != 5'd0) m_regs[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(pfx);
  endtask

  task automatic idle_wb(input string pfx, input logic [4:0] wa, input logic [31:0] wd);
    cycle(pfx, 1'b0, 1'b0, 32'd0, 1'b1, wa, wd, 1'b1);
  endtask

  task automatic send(input string pfx, input logic [31:0] ins);
    cycle(pfx, 1'b0, 1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  initial begin
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] ins;
    logic [31:0] op_sel;

    // Reset state.
    cycle("rst0", 1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle("rst1", 1'b1, 1'b0, 32'd0, 1'b1, 5'd9, 32'h5, 1'b1);
    check_eq("rst.instr_ready", {31'd0, instr_ready}, 32'd1);
    check_eq("rst.ALUop", {28'd0, ALUop}, 32'hF);

    // All registers read zero after reset.
    for (int i = 1; i < 32; i++) send("zero", mk(7'h00, 5'(i), 5'(i), 3'b000, 5'd1));

    // Basic ops.
    idle_wb("wb1", 5'd1, 32'd12);
    idle_wb("wb2", 5'd2, 32'd18);
    send("add", 32'h002081B3);
    check_eq("add.rs1", rs1, 32'd12);
    check_eq("add.rs2", rs2, 32'd18);
    check_eq("add.op", {28'd0, ALUop}, 32'h9);
    send("sub", 32'h401101B3);
    check_eq("sub.op", {28'd0, ALUop}, 32'h1);
    check_eq("sub.rs1", rs1, 32'd18);
    send("xor", mk(7'h00, 5'd2, 5'd1, 3'b100, 5'd4));
    send("or",  mk(7'h00, 5'd2, 5'd1, 3'b110, 5'd4));
    send("and", mk(7'h00, 5'd2, 5'd1, 3'b111, 5'd4));
    send("sll", mk(7'h00, 5'd2, 5'd1, 3'b001, 5'd4));
    send("srl", mk(7'h00, 5'd2, 5'd1, 3'b101, 5'd4));
    check_eq("srl.op", {28'd0, ALUop}, 32'hD);

    // Same-cycle bypass and x0 writes.
    cycle("byp", 1'b0, 1'b1, mk(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    check_eq("byp.rs1", rs1, 32'hDEADBEEF);
    cycle("bypB", 1'b0, 1'b1, mk(7'h00, 5'd7, 5'd1, 3'b000, 5'd6), 1'b1, 5'd7, 32'h1234, 1'b1);
    idle_wb("wbx0", 5'd0, 32'd7);
    send("rdx0", mk(7'h00, 5'd0, 5'd0, 3'b000, 5'd1));
    check_eq("x0.rs1", rs1, 32'd0);

    // Backpressure: held entry stable, later write-back must not refresh it.
    send("bp_load", mk(7'h00, 5'd2, 5'd1, 3'b111, 5'd8));
    cycle("bp0", 1'b0, 1'b1, mk(7'h00, 5'd1, 5'd2, 3'b000, 5'd9), 1'b1, 5'd1, 32'hAAAA, 1'b0);
    cycle("bp1", 1'b0, 1'b1, mk(7'h00, 5'd1, 5'd2, 3'b000, 5'd9), 1'b1, 5'd2, 32'hBBBB, 1'b0);
    cycle("bp2", 1'b0, 1'b1, mk(7'h00, 5'd1, 5'd2, 3'b000, 5'd9), 1'b0, 5'd0, 32'd0, 1'b0);
    check_eq("bp.rs1_held", rs1, 32'd12);
    cycle("bp3", 1'b0, 1'b1, mk(7'h00, 5'd1, 5'd2, 3'b000, 5'd9), 1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("bp.next_rd", {27'd0, rd}, 32'd9);
    send("bp4", mk(7'h20, 5'd1, 5'd2, 3'b000, 5'd10));
    send("bp5", mk(7'h00, 5'd1, 5'd2, 3'b100, 5'd11));

    // Illegal encodings and reset while holding.
    send("ill_opc", 32'h00208193 & 32'hFFFFFF93);
    check_eq("ill_opc.ill", {31'd0, illegal}, 32'd1);
    send("ill_f7", mk(7'h20, 5'd2, 5'd1, 3'b100, 5'd3));
    check_eq("ill_f7.op", {28'd0, ALUop}, 32'hF);
    cycle("hold", 1'b0, 1'b1, mk(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 5'd0, 32'd0, 1'b0);
    cycle("rst_hold", 1'b1, 1'b0, 32'd0, 1'b1, 5'd3, 32'h77, 1'b0);
    check_eq("rst_hold.valid", {31'd0, out_valid}, 32'd0);
    send("post_rst", mk(7'h00, 5'd3, 5'd1, 3'b000, 5'd3));

    // Random traffic; small address range makes bypass/hazard cases frequent.
    for (int n = 0; n < 3000; n++) begin
      op_sel = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      case (op_sel)
        0, 1, 2, 3, 4: f7 = 7'h00;
        5, 6:          f7 = 7'h20;
        default:       f7 = 7'($urandom);
      endcase
      ins = mk(f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3, 5'($urandom));
      if ($urandom_range(0, 15) == 0) ins[6:0] = 7'($urandom);
      cycle("rnd", ($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0), ins,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
